// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA counters, sync/blank and an early pixel request that hides
// RD_LAT cycles of source latency. Define VGA_TEST_PATTERN_EN to add the iTestMode colour-bar source.
module vga_timing_gen #(
   parameter int H_ACT  = 640,
   parameter int H_FP   = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int V_ACT  = 480,
   parameter int V_FP   = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33,
   parameter bit HS_POL = 1'b0,
   parameter bit VS_POL = 1'b0,
   parameter int CW     = 8,
   parameter int RD_LAT = 1,
   parameter int CNT_W  = 11
) (
   input  logic             iCLK,
   input  logic             iRST_N,
   input  logic             iEN,
`ifdef VGA_TEST_PATTERN_EN
   input  logic             iTestMode,
`endif
   input  logic [CW-1:0]    iRed,
   input  logic [CW-1:0]    iGreen,
   input  logic [CW-1:0]    iBlue,
   output logic             oReq,
   output logic [CNT_W-1:0] oX,
   output logic [CNT_W-1:0] oY,
   output logic [CNT_W-1:0] H_Cont,
   output logic [CNT_W-1:0] V_Cont,
   output logic             oFrameStart,
   output logic             oLineStart,
   output logic [CW-1:0]    oVGA_R,
   output logic [CW-1:0]    oVGA_G,
   output logic [CW-1:0]    oVGA_B,
   output logic             oVGA_H_SYNC,
   output logic             oVGA_V_SYNC,
   output logic             oVGA_BLANK,
   output logic             oVGA_SYNC,
   output logic             oVGA_CLK
);
   localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);
   // Region bounds are one bit wider so a total of exactly 2**CNT_W cannot wrap a bound to 0.
   localparam logic [CNT_W:0] H_ACT_E = (CNT_W+1)'(H_ACT);
   localparam logic [CNT_W:0] HS_BEG  = (CNT_W+1)'(H_ACT + H_FP);
   localparam logic [CNT_W:0] HS_END  = (CNT_W+1)'(H_ACT + H_FP + H_SYNC);
   localparam logic [CNT_W:0] V_ACT_E = (CNT_W+1)'(V_ACT);
   localparam logic [CNT_W:0] VS_BEG  = (CNT_W+1)'(V_ACT + V_FP);
   localparam logic [CNT_W:0] VS_END  = (CNT_W+1)'(V_ACT + V_FP + V_SYNC);
`ifdef VGA_TEST_PATTERN_EN
   localparam int TAP_W = 6;
`else
   localparam int TAP_W = 3;
`endif

   logic             run;
   logic             adv;
   logic [CNT_W-1:0] hCnt;
   logic [CNT_W-1:0] vCnt;
   logic [CNT_W:0]   hExt;
   logic [CNT_W:0]   vExt;
   logic             deNow;
   logic             hsNow;
   logic             vsNow;
   logic [TAP_W-1:0] tapNow;
   logic [TAP_W-1:0] tapOut;
   logic             deOut;
   logic             hsOut;
   logic             vsOut;
   logic [CW-1:0]    srcR;
   logic [CW-1:0]    srcG;
   logic [CW-1:0]    srcB;

   // Holding the counters for the first edge after reset makes (0,0) the first request.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) run <= 1'b0;
      else         run <= 1'b1;
   end

   assign adv = run & iEN;

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         hCnt <= '0;
         vCnt <= '0;
      end else if (adv) begin
         if (hCnt == H_LAST) begin
            hCnt <= '0;
            vCnt <= (vCnt == V_LAST) ? '0 : vCnt + CNT_W'(1);
         end else begin
            hCnt <= hCnt + CNT_W'(1);
         end
      end
   end

   assign hExt  = {1'b0, hCnt};
   assign vExt  = {1'b0, vCnt};
   assign deNow = (hExt < H_ACT_E) && (vExt < V_ACT_E);
   assign hsNow = (hExt >= HS_BEG) && (hExt < HS_END);
   assign vsNow = (vExt >= VS_BEG) && (vExt < VS_END);

   assign oReq        = deNow & adv;
   assign oX          = hCnt;
   assign oY          = vCnt;
   assign H_Cont      = hCnt;
   assign V_Cont      = vCnt;
   assign oLineStart  = run && (hCnt == '0);
   assign oFrameStart = run && (hCnt == '0) && (vCnt == '0);
   assign oVGA_SYNC   = 1'b0;
   assign oVGA_CLK    = iCLK;

`ifdef VGA_TEST_PATTERN_EN
   localparam int BAR_W = (H_ACT >= 8) ? H_ACT / 8 : 1;
   logic [6:0] barEdge;
   logic [2:0] barNow;
   logic [2:0] barRgb;
   genvar gi;
   // Thermometer of bar boundaries passed; its population count is the bar index.
   for (gi = 0; gi < 7; gi++) begin : gBarEdge
      assign barEdge[gi] = hExt >= (CNT_W+1)'((gi + 1) * BAR_W);
   end
   assign barNow = 3'($countones(barEdge));
   assign tapNow = {barNow, vsNow, hsNow, deNow};
`else
   assign tapNow = {vsNow, hsNow, deNow};
`endif

   // Timing flags ride alongside the outstanding read so they meet the colour it returns.
   if (RD_LAT == 0) begin : gNoDly
      assign tapOut = tapNow;
   end else begin : gDly
      logic [TAP_W-1:0] stage [RD_LAT];
      always_ff @(posedge iCLK or negedge iRST_N) begin
         if (!iRST_N) begin
            for (int i = 0; i < RD_LAT; i++) stage[i] <= '0;
         end else if (adv) begin
            stage[0] <= tapNow;
            for (int i = 1; i < RD_LAT; i++) stage[i] <= stage[i-1];
         end
      end
      assign tapOut = stage[RD_LAT-1];
   end

   assign {vsOut, hsOut, deOut} = tapOut[2:0];

`ifdef VGA_TEST_PATTERN_EN
   // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black (bits are R,G,B).
   always_comb begin
      barRgb = 3'b000;
      case (tapOut[5:3])
         3'd0:    barRgb = 3'b111;
         3'd1:    barRgb = 3'b110;
         3'd2:    barRgb = 3'b011;
         3'd3:    barRgb = 3'b010;
         3'd4:    barRgb = 3'b101;
         3'd5:    barRgb = 3'b100;
         3'd6:    barRgb = 3'b001;
         default: barRgb = 3'b000;
      endcase
   end
   assign srcR = iTestMode ? {CW{barRgb[2]}} : iRed;
   assign srcG = iTestMode ? {CW{barRgb[1]}} : iGreen;
   assign srcB = iTestMode ? {CW{barRgb[0]}} : iBlue;
`else
   assign srcR = iRed;
   assign srcG = iGreen;
   assign srcB = iBlue;
`endif

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         oVGA_R      <= '0;
         oVGA_G      <= '0;
         oVGA_B      <= '0;
         oVGA_BLANK  <= 1'b0;
         oVGA_H_SYNC <= ~HS_POL;
         oVGA_V_SYNC <= ~VS_POL;
      end else if (adv) begin
         oVGA_R      <= deOut ? srcR : '0;
         oVGA_G      <= deOut ? srcG : '0;
         oVGA_B      <= deOut ? srcB : '0;
         oVGA_BLANK  <= deOut;
         oVGA_H_SYNC <= hsOut ? HS_POL : ~HS_POL;
         oVGA_V_SYNC <= vsOut ? VS_POL : ~VS_POL;
      end
   end
endmodule
